// File: rtl/drive_pkg.sv
// Shared definitions for the SPI-controlled stepper driver.
// Holds the command word layout, the coil sequences ({A,B,C,D}, A in the
// MSB) and the default rate prescaler.
package drive_pkg;

  localparam int unsigned CMD_W            = 24;
  localparam int unsigned PRESCALE_DEFAULT = 1000;

  // Bit positions inside the ctrl byte
  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_DIR_BIT  = 1;
  localparam int unsigned CTRL_HALF_BIT = 2;

  // Command word: [23:16] ctrl, [15:8] rate, [7:0] duty
  typedef struct packed {
    logic [7:0] ctrl;
    logic [7:0] rate;
    logic [7:0] duty;
  } cmd_t;

  // Two-phase-on full-step sequence: AB, BC, CD, DA
  localparam logic [3:0] FULL_SEQ [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};

  // Half-step sequence: A, AB, B, BC, C, CD, D, DA
  localparam logic [3:0] HALF_SEQ [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                          4'b0010, 4'b0011, 4'b0001, 4'b1001};

  // Coil pattern for a phase index in the selected mode
  function automatic logic [3:0] seq_pattern(input logic [2:0] idx, input logic half);
    if (half) begin
      return HALF_SEQ[idx];
    end
    return FULL_SEQ[idx[1:0]];
  endfunction

endpackage

// File: rtl/spi_rx.sv
// SPI receive shift register, clocked directly by sck.
// Ports: sck (SPI clock), cs (frame enable, active high), sdi (serial data,
// MSB first), word (last CMD_W bits received).
// Deliberately not reset: it only holds data and is sampled by the clk
// domain while cs is low, when it is static.
module spi_rx
  import drive_pkg::*;
(
  input  logic             sck,
  input  logic             cs,
  input  logic             sdi,
  output logic [CMD_W-1:0] word
);

  always_ff @(posedge sck) begin
    if (cs) begin
      word <= {word[CMD_W-2:0], sdi};
    end
  end

endmodule

// File: rtl/drive_top.sv
// Four-phase stepper driver top level.
// Ports: clk, reset (synchronous, active low), cs/sck/sdi (SPI command
// input), A/B/C/D (registered coil drives).
// A 24-bit command {ctrl, rate, duty} is committed on the falling edge of cs;
// the coils then step every rate ticks, gated by an 8-bit PWM duty.
// Build option: define HALF_STEP_EN to enable the 8-entry half-step sequence
// (ctrl bit2); otherwise only full-step exists.
module drive_top
  import drive_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic cs,
  input  logic sck,
  input  logic sdi,
  output logic A,
  output logic B,
  output logic C,
  output logic D
);

  localparam int unsigned TICK_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
`ifdef HALF_STEP_EN
  localparam int unsigned PH_W = 3;
`else
  localparam int unsigned PH_W = 2;
`endif

  logic [CMD_W-1:0]  word;
  cmd_t              cmd_w;
  logic              cs_s1, cs_s2, cs_d;
  logic              commit_c;
  logic              en_q, dir_q, half_c;
  logic [7:0]        rate_q, duty_q;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_c;
  logic [7:0]        per_cnt;
  logic              step_c;
  logic [PH_W-1:0]   phase, phase_n;
  logic [7:0]        pwm_cnt;
  logic              pwm_on_c;
  logic              unused_c;

  spi_rx u_spi_rx (
    .sck  (sck),
    .cs   (cs),
    .sdi  (sdi),
    .word (word)
  );

  assign cmd_w = cmd_t'(word);

  // cs synchronizer plus edge register; a fall commits the word
  always_ff @(posedge clk) begin
    if (!reset) begin
      cs_s1 <= 1'b0;
      cs_s2 <= 1'b0;
      cs_d  <= 1'b0;
    end else begin
      cs_s1 <= cs;
      cs_s2 <= cs_s1;
      cs_d  <= cs_s2;
    end
  end

  assign commit_c = cs_d & ~cs_s2;

  // Command registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      en_q   <= 1'b0;
      dir_q  <= 1'b0;
      rate_q <= 8'd0;
      duty_q <= 8'd0;
    end else if (commit_c) begin
      en_q   <= cmd_w.ctrl[CTRL_EN_BIT];
      dir_q  <= cmd_w.ctrl[CTRL_DIR_BIT];
      rate_q <= cmd_w.rate;
      duty_q <= cmd_w.duty;
    end
  end

`ifdef HALF_STEP_EN
  logic half_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      half_q <= 1'b0;
    end else if (commit_c) begin
      half_q <= cmd_w.ctrl[CTRL_HALF_BIT];
    end
  end

  assign half_c   = half_q;
  assign unused_c = ^cmd_w.ctrl[7:3];
`else
  assign half_c   = 1'b0;
  assign unused_c = ^{cmd_w.ctrl[7:3], cmd_w.ctrl[CTRL_HALF_BIT]};
`endif

  // Rate prescaler; restarted on commit so the first step lands rate ticks later
  assign tick_c = (tick_cnt == TICK_W'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (commit_c || tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Step period counter; a commit in the same cycle discards the step
  assign step_c = tick_c & en_q & (rate_q != 8'd0) & ((per_cnt + 8'd1) == rate_q) & ~commit_c;

  always_ff @(posedge clk) begin
    if (!reset) begin
      per_cnt <= 8'd0;
    end else if (commit_c) begin
      per_cnt <= 8'd0;
    end else if (tick_c) begin
      per_cnt <= step_c ? 8'd0 : per_cnt + 8'd1;
    end
  end

  // Next phase index: mode remap on commit, +/-1 on step
  always_comb begin
    phase_n = phase;
    if (commit_c) begin
`ifdef HALF_STEP_EN
      // Remap only an index that was being driven; an idle index is kept raw
      if (en_q && (cmd_w.ctrl[CTRL_HALF_BIT] != half_q)) begin
        phase_n = cmd_w.ctrl[CTRL_HALF_BIT] ? {phase[1:0], 1'b1} : {1'b0, phase[2:1]};
      end
`endif
    end else if (step_c) begin
`ifdef HALF_STEP_EN
      if (half_q) begin
        phase_n = dir_q ? phase - 3'd1 : phase + 3'd1;
      end else begin
        phase_n = {1'b0, (dir_q ? phase[1:0] - 2'd1 : phase[1:0] + 2'd1)};
      end
`else
      phase_n = dir_q ? phase - 2'd1 : phase + 2'd1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase <= '0;
    end else begin
      phase <= phase_n;
    end
  end

  // Free-running PWM; full duty stays on for all 256 counts
  always_ff @(posedge clk) begin
    if (!reset) begin
      pwm_cnt <= 8'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  assign pwm_on_c = (pwm_cnt < duty_q) || (duty_q == 8'hFF);

  // Coil output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      {A, B, C, D} <= 4'b0000;
    end else begin
      {A, B, C, D} <= seq_pattern(3'(phase), half_c) & {4{pwm_on_c & en_q}};
    end
  end

endmodule

// File: tb/tb_drive_top.sv
// Scoreboard bench for drive_top (PRESCALE = 2). Stimulus pushes expected
// coil patterns with their expected cycle; a monitor pops one entry on every
// change of {A,B,C,D}. Half-step expectations follow HALF_STEP_EN.
module tb_drive_top;

  localparam int unsigned PRE = 2;

  localparam logic [3:0] P_0  = 4'b0000;
  localparam logic [3:0] P_A  = 4'b1000;
  localparam logic [3:0] P_AB = 4'b1100;
  localparam logic [3:0] P_B  = 4'b0100;
  localparam logic [3:0] P_BC = 4'b0110;
  localparam logic [3:0] P_CD = 4'b0011;
  localparam logic [3:0] P_DA = 4'b1001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cs = 1'b0;
  logic sck = 1'b0;
  logic sdi = 1'b0;
  logic A, B, C, D;

  typedef struct {
    logic [3:0] pat;
    int         cyc;
    string      name;
  } exp_t;

  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic       mon_en = 1'b0;
  logic [3:0] last_obs = 4'b0000;
  logic [3:0] last_exp = 4'b0000;

  drive_top #(.PRESCALE(PRE)) dut (
    .clk   (clk),
    .reset (reset),
    .cs    (cs),
    .sck   (sck),
    .sdi   (sdi),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each output change must match the next expected pattern within +-1 cycle
  always @(negedge clk) begin
    logic [3:0] cur;
    exp_t       e;
    cur = {A, B, C, D};
    if (mon_en && (cur !== last_obs)) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change: got %b at cycle %0d, expected no change", cur, cyc);
      end else begin
        e = q.pop_front();
        if ((cur !== e.pat) || (cyc < e.cyc - 1) || (cyc > e.cyc + 1)) begin
          fails++;
          $display("FAIL %s: got %b at cycle %0d, expected %b at cycle %0d+-1",
                   e.name, cur, cyc, e.pat, e.cyc);
        end
      end
    end
    last_obs = cur;
  end

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic expect_pat(input logic [3:0] p, input int c, input string n);
    if (p != last_exp) begin
      q.push_back('{pat: p, cyc: c, name: n});
      last_exp = p;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0) && (n < budget)) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending events, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    if (mon_en) expect_pat(P_0, cyc + 1, "reset_clear");
    else last_exp = P_0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Shift nbits of w (MSB first) in one frame; c = cycle count when cs drops
  task automatic send(input logic [23:0] w, input int nbits, output int c);
    @(posedge clk);
    #1 cs = 1'b1;
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = w[i];
      #2 sck = 1'b1;
      #3 sck = 1'b0;
    end
    @(posedge clk);
    #1 cs = 1'b0;
    c = cyc;
  endtask

  task automatic count_on(input string name, input int req);
    int hi;
    hi = 0;
    repeat (6) @(negedge clk);
    repeat (256) begin
      @(negedge clk);
      if (|{A, B, C, D}) hi++;
    end
    check(name, hi, req);
  endtask

  initial begin
    int c;

    // Reset with SPI traffic: nothing may be committed
    send(24'h0114FF, 24, c);
    repeat (4) @(negedge clk);
    check("reset_outputs", int'({A, B, C, D}), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (20) @(negedge clk);
    check("no_commit_in_reset", int'({A, B, C, D}), 0);
    last_exp = P_0;
    mon_en = 1'b1;

    // Forward full-step, rate 20 ticks = 40 clk
    send(24'h0114FF, 24, c);
    expect_pat(P_AB, c + 4,   "fwd_commit_ab");
    expect_pat(P_BC, c + 44,  "fwd_bc");
    expect_pat(P_CD, c + 84,  "fwd_cd");
    expect_pat(P_DA, c + 124, "fwd_da");
    expect_pat(P_AB, c + 164, "fwd_ab");
    drain(300);

    // Reverse from AB
    send(24'h0314FF, 24, c);
    expect_pat(P_AB, c + 4,   "rev_commit_ab");
    expect_pat(P_DA, c + 44,  "rev_da");
    expect_pat(P_CD, c + 84,  "rev_cd");
    expect_pat(P_BC, c + 124, "rev_bc");
    drain(300);

    // Half-step request after reset, rate 10 ticks = 20 clk
    do_reset();
    send(24'h050AFF, 24, c);
`ifdef HALF_STEP_EN
    expect_pat(P_A,  c + 4,  "half_a");
    expect_pat(P_AB, c + 24, "half_ab");
    expect_pat(P_B,  c + 44, "half_b");
`else
    expect_pat(P_AB, c + 4,  "mode_full_ab");
    expect_pat(P_BC, c + 24, "mode_full_bc");
    expect_pat(P_CD, c + 44, "mode_full_cd");
`endif
    drain(200);

    // PWM duty: half, zero, full
    do_reset();
    drain(20);
    mon_en = 1'b0;
    send(24'h011480, 24, c);
    count_on("pwm_duty_80", 128);
    send(24'h011400, 24, c);
    count_on("pwm_duty_00", 0);
    send(24'h0114FF, 24, c);
    count_on("pwm_duty_ff", 256);
    do_reset();
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // Disable holds the index; re-enable resumes it
    send(24'h0114FF, 24, c);
    expect_pat(P_AB, c + 4,  "hold_ab");
    expect_pat(P_BC, c + 44, "hold_bc");
    drain(100);
    send(24'h001480, 24, c);
    expect_pat(P_0, c + 4, "disable_off");
    drain(20);
    repeat (100) @(posedge clk);
    send(24'h0114FF, 24, c);
    expect_pat(P_BC, c + 4,  "resume_bc");
    expect_pat(P_CD, c + 44, "resume_cd");
    drain(100);

    // Short frame: previous low byte becomes ctrl
    do_reset();
    send(24'h000001, 24, c);
    repeat (5) @(posedge clk);
    send(24'h0014FF, 16, c);
    expect_pat(P_AB, c + 4,  "short_ab");
    expect_pat(P_BC, c + 44, "short_bc");
    drain(100);

    // Reset mid-frame; cs falls while in reset, so no commit
    @(posedge clk);
    #1 cs = 1'b1;
    for (int i = 23; i >= 16; i--) begin
      sdi = 1'(24'h0314FF >> i);
      #2 sck = 1'b1;
      #3 sck = 1'b0;
    end
    @(posedge clk);
    #1 reset = 1'b0;
    expect_pat(P_0, cyc + 1, "reset_mid_frame");
    for (int i = 15; i >= 0; i--) begin
      sdi = 1'(24'h0314FF >> i);
      #2 sck = 1'b1;
      #3 sck = 1'b0;
    end
    @(posedge clk);
    #1 cs = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    repeat (80) @(posedge clk);
    drain(5);
    check("mid_frame_outputs", int'({A, B, C, D}), 0);
    check("queue_empty_end", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
